// File: rtl/trdb_branch_map_acc_pkg.sv
// Shared constants and types for the trace encoder branch map.
// Optional per-outcome statistics live behind TRDB_BRANCH_STATS_EN in the top.
package trdb_branch_map_acc_pkg;

  localparam int BRANCH_MAP_LEN   = 31;
  localparam int BRANCH_COUNT_LEN = $clog2(BRANCH_MAP_LEN + 1);
  localparam int BRANCH_NRET_MAX  = 4;
  localparam int BRANCH_STAT_W    = 16;

  localparam logic BRANCH_TAKEN  = 1'b0;
  localparam logic BRANCH_NTAKEN = 1'b1;

  typedef logic [BRANCH_MAP_LEN-1:0] branch_map_t;

endpackage

// File: rtl/trdb_branch_map_acc_prefix_sum.sv
// Exclusive prefix popcount over NRET flags: o_prefix[k] counts set bits below k,
// o_total counts all of them.
module trdb_bm_prefix_sum
  import trdb_branch_map_acc_pkg::*;
#(
  parameter int NRET = 2,
  parameter int CW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]         i_bits,
  output logic [NRET-1:0][CW-1:0] o_prefix,
  output logic [CW-1:0]           o_total
);

  logic [CW-1:0] w_run;

  always_comb begin
    w_run    = '0;
    o_prefix = '0;
    for (int k = 0; k < NRET; k++) begin
      o_prefix[k] = w_run;
      w_run       = w_run + CW'(i_bits[k]);
    end
    o_total = w_run;
  end

endmodule

// File: rtl/trdb_branch_map_acc.sv
// Multi-retirement branch map accumulator; records up to NRET branch outcomes per cycle.
// Define TRDB_BRANCH_STATS_EN to add saturating taken/not-taken counters (taken_cnt_o, ntaken_cnt_o).
module trdb_branch_map_acc
  import trdb_branch_map_acc_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int MAP_LEN   = BRANCH_MAP_LEN,
  parameter int COUNT_LEN = $clog2(MAP_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRET-1:0]      valid_i,
  input  logic [NRET-1:0]      branch_i,
  input  logic [NRET-1:0]      taken_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  output logic [MAP_LEN-1:0]   map_o,
  output logic [COUNT_LEN-1:0] count_o,
  output logic                 full_o
`ifdef TRDB_BRANCH_STATS_EN
  ,
  output logic [BRANCH_STAT_W-1:0] taken_cnt_o,
  output logic [BRANCH_STAT_W-1:0] ntaken_cnt_o
`endif
);

  localparam int CW = $clog2(NRET + 1);

  logic [MAP_LEN-1:0]     r_map;
  logic [MAP_LEN-1:0]     w_nextMap;
  logic [COUNT_LEN-1:0]   r_count;
  logic [COUNT_LEN-1:0]   w_nextCount;
  logic [COUNT_LEN-1:0]   w_base;
  logic [NRET-1:0]        w_acc;
  logic [NRET-1:0][CW-1:0] w_prefix;
  logic [CW-1:0]          w_total;
  logic [31:0]            w_free;
  logic                   w_ready;

  // Readiness looks only at registered occupancy so upstream never sees a flush-dependent path.
  assign w_free  = 32'(MAP_LEN) - 32'(r_count);
  assign w_ready = w_free >= 32'(NRET);
  assign w_acc   = valid_i & branch_i & {NRET{w_ready}};
  assign w_base  = flush_i ? '0 : r_count;

  trdb_bm_prefix_sum #(
    .NRET (NRET),
    .CW   (CW)
  ) u_prefix (
    .i_bits   (w_acc),
    .o_prefix (w_prefix),
    .o_total  (w_total)
  );

  always_comb begin
    w_nextMap = flush_i ? '0 : r_map;
    for (int k = 0; k < NRET; k++) begin
      if (w_acc[k]) begin
        for (int i = 0; i < MAP_LEN; i++) begin
          if (32'(i) == 32'(w_base) + 32'(w_prefix[k])) begin
            w_nextMap[i] = taken_i[k] ? BRANCH_TAKEN : BRANCH_NTAKEN;
          end
        end
      end
    end
  end

  assign w_nextCount = w_base + COUNT_LEN'(w_total);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_map   <= '0;
      r_count <= '0;
    end else begin
      r_map   <= w_nextMap;
      r_count <= w_nextCount;
    end
  end

  assign ready_o = w_ready;
  assign map_o   = r_map;
  assign count_o = r_count;
  assign full_o  = (r_count == COUNT_LEN'(MAP_LEN));

`ifdef TRDB_BRANCH_STATS_EN
  localparam int SW = BRANCH_STAT_W + 1;

  logic [BRANCH_STAT_W-1:0] r_takenCnt;
  logic [BRANCH_STAT_W-1:0] r_ntakenCnt;
  logic [SW-1:0]            w_takenSum;
  logic [SW-1:0]            w_ntakenSum;

  // One spare bit on the sums is enough: at most NRET increments are added to a 16-bit value.
  always_comb begin
    w_takenSum  = {1'b0, r_takenCnt};
    w_ntakenSum = {1'b0, r_ntakenCnt};
    for (int k = 0; k < NRET; k++) begin
      w_takenSum  = w_takenSum + SW'(w_acc[k] & taken_i[k]);
      w_ntakenSum = w_ntakenSum + SW'(w_acc[k] & ~taken_i[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_takenCnt  <= '0;
      r_ntakenCnt <= '0;
    end else begin
      r_takenCnt  <= w_takenSum[BRANCH_STAT_W] ? '1 : w_takenSum[BRANCH_STAT_W-1:0];
      r_ntakenCnt <= w_ntakenSum[BRANCH_STAT_W] ? '1 : w_ntakenSum[BRANCH_STAT_W-1:0];
    end
  end

  assign taken_cnt_o  = r_takenCnt;
  assign ntaken_cnt_o = r_ntakenCnt;
`endif

endmodule

// File: tb/tb_trdb_branch_map_acc.sv
// Self-checking bench for trdb_branch_map_acc (NRET=2, MAP_LEN=31): vector table,
// hand-written full/flush/reset sequences, and stats saturation when TRDB_BRANCH_STATS_EN is set.
module tb_trdb_branch_map_acc;
  import trdb_branch_map_acc_pkg::*;

  localparam int NRET      = 2;
  localparam int MAP_LEN   = 31;
  localparam int COUNT_LEN = 5;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NRET-1:0]      valid_i = '0;
  logic [NRET-1:0]      branch_i = '0;
  logic [NRET-1:0]      taken_i = '0;
  logic                 flush_i = 1'b0;
  logic                 ready_o;
  logic [MAP_LEN-1:0]   map_o;
  logic [COUNT_LEN-1:0] count_o;
  logic                 full_o;
`ifdef TRDB_BRANCH_STATS_EN
  logic [15:0] taken_cnt_o;
  logic [15:0] ntaken_cnt_o;
`endif

  trdb_branch_map_acc #(
    .NRET      (NRET),
    .MAP_LEN   (MAP_LEN),
    .COUNT_LEN (COUNT_LEN)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .branch_i (branch_i),
    .taken_i  (taken_i),
    .ready_o  (ready_o),
    .flush_i  (flush_i),
    .map_o    (map_o),
    .count_o  (count_o),
    .full_o   (full_o)
`ifdef TRDB_BRANCH_STATS_EN
    ,
    .taken_cnt_o  (taken_cnt_o),
    .ntaken_cnt_o (ntaken_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [MAP_LEN-1:0] map;
    int                 count;
    logic               full;
    int                 takenCnt;
    int                 ntakenCnt;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  branch;
    logic [1:0]  taken;
    logic        flush;
    logic [31:0] expMap;
    int          expCount;
  } vec_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  // Behavioural reference: each accepted branch is appended at the current fill level.
  logic [MAP_LEN-1:0] mMap = '0;
  int                 mCount = 0;
  int                 mTaken = 0;
  int                 mNtaken = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL queueUnderflow: actual empty required one entry");
      return;
    end
    e = expQ.pop_front();
    compare("map", 32'(map_o), 32'(e.map));
    compare("count", 32'(count_o), 32'(e.count));
    compare("full", 32'(full_o), 32'(e.full));
`ifdef TRDB_BRANCH_STATS_EN
    compare("takenCnt", 32'(taken_cnt_o), 32'(e.takenCnt));
    compare("ntakenCnt", 32'(ntaken_cnt_o), 32'(e.ntakenCnt));
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with the result checked.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] b,
                               input logic [1:0] t, input logic f);
    logic rdy;
    exp_t e;
    valid_i  = v;
    branch_i = b;
    taken_i  = t;
    flush_i  = f;
    #1;
    rdy = ((MAP_LEN - mCount) >= NRET);
    compare("ready", 32'(ready_o), 32'(rdy));
    if (f) begin
      compare("flushSnapMap", 32'(map_o), 32'(mMap));
      compare("flushSnapCount", 32'(count_o), 32'(mCount));
      mMap   = '0;
      mCount = 0;
    end
    for (int k = 0; k < NRET; k++) begin
      if (v[k] && b[k] && rdy) begin
        mMap[mCount] = t[k] ? BRANCH_TAKEN : BRANCH_NTAKEN;
        mCount++;
        if (t[k]) mTaken = (mTaken < 65535) ? mTaken + 1 : 65535;
        else      mNtaken = (mNtaken < 65535) ? mNtaken + 1 : 65535;
      end
    end
    e.map       = mMap;
    e.count     = mCount;
    e.full      = (mCount == MAP_LEN);
    e.takenCnt  = mTaken;
    e.ntakenCnt = mNtaken;
    expQ.push_back(e);
    @(posedge clk_i);
    #1;
    checkOutput();
    @(negedge clk_i);
  endtask

  // Asserts reset between clock edges and checks that outputs clear without any clock.
  task automatic doReset(input string name);
    #2;
    rst_ni   = 1'b0;
    valid_i  = '0;
    branch_i = '0;
    taken_i  = '0;
    flush_i  = 1'b0;
    #1;
    compare({name, "Map"}, 32'(map_o), 32'h0);
    compare({name, "Count"}, 32'(count_o), 32'h0);
    compare({name, "Full"}, 32'(full_o), 32'h0);
    compare({name, "Ready"}, 32'(ready_o), 32'h1);
`ifdef TRDB_BRANCH_STATS_EN
    compare({name, "TakenCnt"}, 32'(taken_cnt_o), 32'h0);
    compare({name, "NtakenCnt"}, 32'(ntaken_cnt_o), 32'h0);
`endif
    mMap    = '0;
    mCount  = 0;
    mTaken  = 0;
    mNtaken = 0;
    expQ.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{2'b11, 2'b11, 2'b01, 1'b0, 32'h2,  2};
    tbl[1] = '{2'b11, 2'b11, 2'b01, 1'b0, 32'hA,  4};
    tbl[2] = '{2'b11, 2'b11, 2'b01, 1'b0, 32'h2A, 6};
    tbl[3] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h6A, 7};
    tbl[4] = '{2'b00, 2'b11, 2'b11, 1'b0, 32'h6A, 7};
    tbl[5] = '{2'b11, 2'b00, 2'b00, 1'b0, 32'h6A, 7};
    tbl[6] = '{2'b00, 2'b00, 2'b00, 1'b1, 32'h0,  0};
    tbl[7] = '{2'b11, 2'b11, 2'b11, 1'b1, 32'h0,  2};
    tbl[8] = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h4,  3};
    tbl[9] = '{2'b10, 2'b10, 2'b00, 1'b0, 32'hC,  4};

    @(negedge clk_i);
    doReset("powerOn");

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].branch, tbl[i].taken, tbl[i].flush);
      compare($sformatf("vec%0dMap", i), 32'(map_o), tbl[i].expMap);
      compare($sformatf("vec%0dCount", i), 32'(count_o), 32'(tbl[i].expCount));
    end

    $display("[TB] fill to full and hold");
    doReset("fillReset");
    for (int i = 0; i < 14; i++) applyStimulus(2'b11, 2'b11, 2'b01, 1'b0);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    compare("count29", 32'(count_o), 32'd29);
    compare("ready29", 32'(ready_o), 32'h1);
    applyStimulus(2'b11, 2'b11, 2'b10, 1'b0);
    compare("count31", 32'(count_o), 32'd31);
    compare("full31", 32'(full_o), 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 2'b11, 2'b11, 1'b0);
    compare("holdReady", 32'(ready_o), 32'h0);

    $display("[TB] flush while full");
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1);
    compare("flushFullCount", 32'(count_o), 32'h0);
    compare("flushFullMap", 32'(map_o), 32'h0);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    compare("reofferCount", 32'(count_o), 32'h1);
    compare("reofferMap", 32'(map_o), 32'h1);

    $display("[TB] flush with concurrent branches");
    doReset("flushAccReset");
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 2'b11, 2'b01, 1'b0);
    compare("count10Map", 32'(map_o), 32'h2AA);
    applyStimulus(2'b11, 2'b11, 2'b11, 1'b1);
    compare("flushAccCount", 32'(count_o), 32'h2);
    compare("flushAccMap", 32'(map_o), 32'h0);

    $display("[TB] async reset mid-stream");
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
    doReset("midReset");
    applyStimulus(2'b11, 2'b11, 2'b01, 1'b0);
    compare("postResetMap", 32'(map_o), 32'h2);
    compare("postResetCount", 32'(count_o), 32'h2);

`ifdef TRDB_BRANCH_STATS_EN
    $display("[TB] stats saturation");
    doReset("statsReset");
    for (int i = 0; i < 35000; i++) applyStimulus(2'b11, 2'b11, 2'b11, 1'b1);
    compare("takenSat", 32'(taken_cnt_o), 32'hFFFF);
    compare("ntakenZero", 32'(ntaken_cnt_o), 32'h0);
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b1);
    compare("takenHeld", 32'(taken_cnt_o), 32'hFFFF);
    compare("ntakenTwo", 32'(ntaken_cnt_o), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
